// File: rtl/pad_bidir_turnaround.sv
// Bidirectional pad controller: RX/TX direction FSM with dead-cycle turnaround,
// registered TX drive and RX sampling, and pad configuration latched per turnaround.
module pad_bidir_turnaround #(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dir_req,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [WIDTH-1:0] tx_data,
    output logic             rx_valid,
    output logic [WIDTH-1:0] rx_data,
    input  logic [1:0]       cfg_ds,
    input  logic             cfg_sr,
    output logic [WIDTH-1:0] pad_a,
    output logic             pad_oe,
    output logic             pad_ie,
    output logic             pad_ds0,
    output logic             pad_ds1,
    output logic             pad_sr,
    input  logic [WIDTH-1:0] pad_y
);

    typedef enum logic [1:0] {
        RX      = 2'd0,
        TURN_TX = 2'd1,
        TX      = 2'd2,
        TURN_RX = 2'd3
    } state_t;

    localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] turn_cnt;
    logic       enter_turn_tx;
    logic       enter_turn_rx;
    logic       tx_fire;
    logic       rx_armed;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RX;
        end else begin
            state <= state_nxt;
        end
    end

    // Pad enables decode straight from the async-reset state register, so a
    // reset drops pad_oe immediately and oe/ie can never overlap.
    always_comb begin
        state_nxt     = state;
        pad_oe        = 1'b0;
        pad_ie        = 1'b0;
        tx_ready      = 1'b0;
        enter_turn_tx = 1'b0;
        enter_turn_rx = 1'b0;
        case (state)
            RX: begin
                pad_ie = 1'b1;
                if (dir_req) begin
                    state_nxt     = TURN_TX;
                    enter_turn_tx = 1'b1;
                end
            end
            TURN_TX: begin
                if (turn_cnt == 4'd0) begin
                    state_nxt = TX;
                end
            end
            TX: begin
                pad_oe   = 1'b1;
                tx_ready = dir_req;
                if (!dir_req) begin
                    state_nxt     = TURN_RX;
                    enter_turn_rx = 1'b1;
                end
            end
            TURN_RX: begin
                if (turn_cnt == 4'd0) begin
                    state_nxt = RX;
                end
            end
            default: state_nxt = RX;
        endcase
    end

    assign tx_fire = tx_valid && tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            turn_cnt <= 4'd0;
        end else if (enter_turn_tx || enter_turn_rx) begin
            turn_cnt <= TURN_LOAD;
        end else if (turn_cnt != 4'd0) begin
            turn_cnt <= turn_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_a <= '0;
        end else if (enter_turn_rx) begin
            pad_a <= '0;
        end else if (tx_fire) begin
            pad_a <= tx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_ds1 <= 1'b0;
            pad_ds0 <= 1'b0;
            pad_sr  <= 1'b0;
        end else if (enter_turn_tx) begin
            pad_ds1 <= cfg_ds[1];
            pad_ds0 <= cfg_ds[0];
            pad_sr  <= cfg_sr;
        end
    end

    // rx_armed suppresses the sample on the first edge after reset release,
    // pushing the earliest rx_valid out to the second edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_armed <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
        end else begin
            rx_armed <= 1'b1;
            if (state == RX && rx_armed) begin
                rx_valid <= 1'b1;
                rx_data  <= pad_y;
            end else begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pad_bidir_turnaround.sv
// Scoreboard bench for pad_bidir_turnaround: stimulus queues expected RX samples
// and TX words, a negedge monitor pops and compares them as the DUT presents them.
module tb_pad_bidir_turnaround;

    localparam int W = 8;

    logic         clk      = 1'b0;
    logic         rst      = 1'b1;
    logic         dir_req  = 1'b0;
    logic         tx_valid = 1'b0;
    logic [W-1:0] tx_data  = '0;
    logic [W-1:0] pad_y    = '0;
    logic [1:0]   cfg_ds   = 2'b00;
    logic         cfg_sr   = 1'b0;

    logic         tx_ready, rx_valid, pad_oe, pad_ie, pad_ds0, pad_ds1, pad_sr;
    logic [W-1:0] rx_data, pad_a;

    logic         tx_ready1, rx_valid1, pad_oe1, pad_ie1, pad_ds01, pad_ds11, pad_sr1;
    logic [W-1:0] rx_data1, pad_a1;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] rxq[$];
    logic [W-1:0] txq[$];
    logic hsPrev = 1'b0;

    pad_bidir_turnaround #(.WIDTH(W), .TURN_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .dir_req(dir_req), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .rx_valid(rx_valid),
        .rx_data(rx_data), .cfg_ds(cfg_ds), .cfg_sr(cfg_sr), .pad_a(pad_a),
        .pad_oe(pad_oe), .pad_ie(pad_ie), .pad_ds0(pad_ds0), .pad_ds1(pad_ds1),
        .pad_sr(pad_sr), .pad_y(pad_y)
    );

    pad_bidir_turnaround #(.WIDTH(W), .TURN_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .dir_req(dir_req), .tx_valid(tx_valid),
        .tx_ready(tx_ready1), .tx_data(tx_data), .rx_valid(rx_valid1),
        .rx_data(rx_data1), .cfg_ds(cfg_ds), .cfg_sr(cfg_sr), .pad_a(pad_a1),
        .pad_oe(pad_oe1), .pad_ie(pad_ie1), .pad_ds0(pad_ds01), .pad_ds1(pad_ds11),
        .pad_sr(pad_sr1), .pad_y(pad_y)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle: drive after the edge, queue what the DUT must later present, sample at negedge.
    task automatic applyStimulus(input logic d, input logic tv, input logic [W-1:0] td,
                                 input logic [W-1:0] y, input bit expectRx, input bit expectTx);
        @(posedge clk);
        #1;
        dir_req  = d;
        tx_valid = tv;
        tx_data  = td;
        pad_y    = y;
        if (expectRx) rxq.push_back(y);
        if (expectTx) txq.push_back(td);
        @(negedge clk);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_pad_oe"},   32'(pad_oe),   32'd0);
        checkOutput({tag, "_pad_ie"},   32'(pad_ie),   32'd1);
        checkOutput({tag, "_pad_a"},    32'(pad_a),    32'd0);
        checkOutput({tag, "_tx_ready"}, 32'(tx_ready), 32'd0);
        checkOutput({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        checkOutput({tag, "_rx_data"},  32'(rx_data),  32'd0);
        checkOutput({tag, "_pad_ds0"},  32'(pad_ds0),  32'd0);
        checkOutput({tag, "_pad_ds1"},  32'(pad_ds1),  32'd0);
        checkOutput({tag, "_pad_sr"},   32'(pad_sr),   32'd0);
    endtask

    always @(negedge clk) begin
        checkOutput("oe_ie_exclusive", 32'(pad_oe & pad_ie), 32'd0);
        checkOutput("oe_ie_exclusive_tc1", 32'(pad_oe1 & pad_ie1), 32'd0);
        if (rx_valid) begin
            if (rxq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rx_unexpected: rx_valid=1 rx_data=0x%0h, expected no sample", rx_data);
            end else begin
                checkOutput("rx_data", 32'(rx_data), 32'(rxq.pop_front()));
            end
        end
        if (hsPrev) begin
            if (txq.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL tx_unexpected: handshake with pad_a=0x%0h, expected none", pad_a);
            end else begin
                checkOutput("pad_a", 32'(pad_a), 32'(txq.pop_front()));
            end
        end
        hsPrev <= tx_valid && tx_ready;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");

        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rx_valid_release", 32'(rx_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h11, 1'b1, 1'b0);
        checkOutput("rx_valid_first_edge", 32'(rx_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h22, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h33, 1'b1, 1'b0);

        // RX -> TX with cfg captured at the turnaround
        cfg_ds = 2'b10;
        cfg_sr = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h44, 1'b1, 1'b0);
        checkOutput("c0_pad_ie", 32'(pad_ie), 32'd1);
        checkOutput("c0_tx_ready", 32'(tx_ready), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h55, 1'b0, 1'b0);
        checkOutput("c1_pad_ie", 32'(pad_ie), 32'd0);
        checkOutput("c1_pad_oe", 32'(pad_oe), 32'd0);
        checkOutput("c1_pad_ds1", 32'(pad_ds1), 32'd1);
        checkOutput("c1_pad_ds0", 32'(pad_ds0), 32'd0);
        checkOutput("c1_pad_sr", 32'(pad_sr), 32'd1);
        checkOutput("c1_tc1_pad_ie", 32'(pad_ie1), 32'd0);
        checkOutput("c1_tc1_pad_oe", 32'(pad_oe1), 32'd0);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h56, 1'b0, 1'b0);
        checkOutput("c2_pad_oe", 32'(pad_oe), 32'd0);
        checkOutput("c2_pad_ie", 32'(pad_ie), 32'd0);
        checkOutput("c2_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("c2_tx_ready", 32'(tx_ready), 32'd0);
        checkOutput("c2_tc1_pad_oe", 32'(pad_oe1), 32'd1);
        applyStimulus(1'b1, 1'b1, 8'hA5, 8'h57, 1'b0, 1'b1);
        checkOutput("c3_pad_oe", 32'(pad_oe), 32'd1);
        checkOutput("c3_pad_ie", 32'(pad_ie), 32'd0);
        checkOutput("c3_tx_ready", 32'(tx_ready), 32'd1);
        cfg_ds = 2'b01;
        cfg_sr = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'h3C, 8'h00, 1'b0, 1'b1);
        checkOutput("c4_pad_ds1", 32'(pad_ds1), 32'd1);
        checkOutput("c4_pad_ds0", 32'(pad_ds0), 32'd0);
        checkOutput("c4_pad_sr", 32'(pad_sr), 32'd1);

        // TX -> RX: tx_valid held high while dir_req falls must not handshake
        applyStimulus(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b0);
        checkOutput("c5_tx_ready", 32'(tx_ready), 32'd0);
        checkOutput("c5_pad_oe", 32'(pad_oe), 32'd1);
        checkOutput("c5_pad_ds1", 32'(pad_ds1), 32'd1);
        checkOutput("c5_pad_sr", 32'(pad_sr), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("c6_pad_oe", 32'(pad_oe), 32'd0);
        checkOutput("c6_pad_ie", 32'(pad_ie), 32'd0);
        checkOutput("c6_pad_a", 32'(pad_a), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("c7_pad_oe", 32'(pad_oe), 32'd0);
        checkOutput("c7_pad_ie", 32'(pad_ie), 32'd0);
        checkOutput("c7_tc1_pad_ie", 32'(pad_ie1), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h66, 1'b1, 1'b0);
        checkOutput("c8_pad_ie", 32'(pad_ie), 32'd1);
        checkOutput("c8_pad_oe", 32'(pad_oe), 32'd0);
        checkOutput("c8_rx_valid", 32'(rx_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h77, 1'b1, 1'b0);
        checkOutput("c9_rx_valid", 32'(rx_valid), 32'd1);

        // dir_req pulse during TURN_TX: TX still entered for one cycle
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h88, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("g1_pad_oe", 32'(pad_oe), 32'd0);
        checkOutput("g1_pad_ie", 32'(pad_ie), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("g2_pad_oe", 32'(pad_oe), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("g3_pad_oe", 32'(pad_oe), 32'd1);
        checkOutput("g3_tx_ready", 32'(tx_ready), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("g4_pad_oe", 32'(pad_oe), 32'd0);
        checkOutput("g4_pad_ie", 32'(pad_ie), 32'd0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 1'b0);
        checkOutput("g6_pad_ie", 32'(pad_ie), 32'd1);

        // Async reset while driving
        cfg_ds = 2'b11;
        cfg_sr = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00, 8'hAB, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h5A, 8'h00, 1'b0, 1'b1);
        checkOutput("h3_pad_oe", 32'(pad_oe), 32'd1);
        checkOutput("h3_pad_ds1", 32'(pad_ds1), 32'd1);
        checkOutput("h3_pad_ds0", 32'(pad_ds0), 32'd1);
        checkOutput("h3_pad_sr", 32'(pad_sr), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checkResetValues("async_reset");
        @(posedge clk);
        @(negedge clk);
        checkOutput("reset_hold_pad_oe", 32'(pad_oe), 32'd0);

        checkOutput("rxq_drained", 32'(rxq.size()), 32'd0);
        checkOutput("txq_drained", 32'(txq.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pad_bidir_turnaround.md
PAD_BIDIR_TURNAROUND -- requirements
Module: pad_bidir_turnaround

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the bidirectional pad bus width in bits.
REQ-002 SHALL have parameter TURN_CYCLES, default 2, range 1..15, meaning the dead cycles on every direction change.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 SHALL have port dir_req, input, 1 bit: 1 requests drive (TX), 0 requests receive (RX).
REQ-006 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-007 SHALL have port tx_ready, output, 1 bit: the block accepts tx_data this cycle.
REQ-008 SHALL have port tx_data, input, WIDTH bits: the word to drive onto the pads.
REQ-009 SHALL have port rx_valid, output, 1 bit: rx_data holds a new sample.
REQ-010 SHALL have port rx_data, output, WIDTH bits: the registered pad sample.
REQ-011 SHALL have port cfg_ds, input, 2 bits: the drive strength {DS1,DS0}.
REQ-012 SHALL have port cfg_sr, input, 1 bit: slew-rate select.
REQ-013 SHALL have port pad_a, output, WIDTH bits: pad A inputs.
REQ-014 SHALL have port pad_oe, output, 1 bit: pad OE, shared by all bits.
REQ-015 SHALL have port pad_ie, output, 1 bit: pad IE, shared by all bits.
REQ-016 SHALL have port pad_ds0, output, 1 bit: pad DS0.
REQ-017 SHALL have port pad_ds1, output, 1 bit: pad DS1.
REQ-018 SHALL have port pad_sr, output, 1 bit: pad SR.
REQ-019 SHALL have port pad_y, input, WIDTH bits: pad Y outputs.

Function
REQ-020 SHALL implement FSM states RX, TURN_TX, TX and TURN_RX.
REQ-021 SHALL, in RX, set pad_ie=1 and pad_oe=0; in TX, set pad_oe=1 and pad_ie=0; in TURN_TX and TURN_RX, set pad_oe=0 and pad_ie=0.
REQ-022 SHALL never assert pad_oe and pad_ie in the same cycle, under any input sequence.
REQ-023 SHALL move RX->TURN_TX when dir_req=1, load the turn counter with TURN_CYCLES-1, and move TURN_TX->TX the cycle after the counter reaches 0.
REQ-024 SHALL move TX->TURN_RX when dir_req=0, using the same counter, and move TURN_RX->RX the cycle after the counter reaches 0.
REQ-025 SHALL ignore dir_req changes during TURN_TX and TURN_RX; the turnaround completes, and the next transition is evaluated in the destination state.
REQ-026 SHALL drive tx_ready = (state==TX) && dir_req, combinationally.
REQ-027 SHALL, on a tx_valid && tx_ready handshake, register tx_data into pad_a at the next edge; pad_a holds its value otherwise.
REQ-028 SHALL clear pad_a to 0 on entry to TURN_RX.
REQ-029 SHALL, while in RX, register pad_y into rx_data every cycle and assert rx_valid the following cycle (1-cycle latency).
REQ-030 SHALL keep rx_valid=0 for any sample taken outside RX, including the first cycle after TURN_RX exits.
REQ-031 SHALL hold rx_data while rx_valid=0.
REQ-032 SHALL sample cfg_ds and cfg_sr into pad_ds1/pad_ds0/pad_sr only on entry to TURN_TX; the values are held through TX.
REQ-033 SHALL ignore cfg changes during TX until the next turnaround.
REQ-034 SHALL, with TURN_CYCLES=1, give exactly one dead cycle per direction change.

Reset
REQ-035 SHALL, while rst=1 and asynchronously, force state=RX, turn counter=0, pad_oe=0, pad_ie=1, pad_a=0, tx_ready=0, rx_valid=0, rx_data=0, pad_ds0=0, pad_ds1=0, pad_sr=0.
REQ-036 SHALL, when rst asserts mid-TX or mid-turnaround, drop pad_oe in the same cycle, without waiting for a clock edge.
REQ-037 SHALL take the first rx_valid after reset deassertion no earlier than the second rising edge after deassertion.

Verification
REQ-038 SHALL verify RX streaming: with dir_req=0, pad_y=0x11,0x22,0x33 on consecutive cycles -> rx_valid high, rx_data=0x11,0x22,0x33, each one cycle later.
REQ-039 SHALL verify RX->TX with TURN_CYCLES=2: dir_req rises at cycle 0 -> pad_ie low at cycle 1, 2 dead cycles, pad_oe high and tx_ready high at cycle 3; tx_data=0xA5 -> pad_a=0xA5 at cycle 4.
REQ-040 SHALL verify TX->RX: dir_req falls with tx_valid=1 -> tx_ready=0 in the same cycle, no handshake, pad_oe low next cycle, pad_a=0, 2 dead cycles, then pad_ie=1, and rx_valid high one cycle later.
REQ-041 SHALL verify a dir_req glitch: 0->1->0 within TURN_TX -> TX is still entered for one cycle, then TURN_RX follows; oe&&ie never seen.
REQ-042 SHALL verify cfg latching: cfg_ds=2'b10 and cfg_sr=1 at turnaround, changed to 2'b01 during TX -> pad_ds1=1, pad_ds0=0, pad_sr=1 held throughout TX.
REQ-043 SHALL verify async reset: rst pulsed mid-TX between clock edges -> pad_oe=0 and pad_ie=1 immediately, and all outputs match the reset values.
